u2_conv_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational U2/SM converter in exe_unit_1. It accepts an N-bit operand and a 2-bit mode over a valid/ready handshake, and performs one of four conversions: U2→SM, SM→U2, ABS or NEG. It returns the result and a per-item error flag two cycles later, and keeps a saturating error counter. It sits between the APB register file and the ALU datapath, so format conversion no longer sits in the ALU's combinational path.

---
 rtl/u2_conv_pipe_pkg.sv | 20 ++
 rtl/u2_conv_pipe_if.sv | 28 ++
 rtl/u2_conv_core.sv | 64 ++++++
 rtl/u2_conv_pipe.sv | 97 +++++++++
 tb/tb_u2_conv_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/u2_conv_pipe_pkg.sv
// exe_conv_pkg: shared types and helpers for the U2/SM conversion pipeline.
//   conv_mode_t : 2-bit conversion mode carried alongside each operand
//   conv_min()  : the most negative two's-complement value of an n-bit word
//                 (1 followed by n-1 zeros), valid for n up to CONV_MAX_W
package exe_conv_pkg;

  typedef enum logic [1:0] {
    CONV_U2_SM = 2'b00,
    CONV_SM_U2 = 2'b01,
    CONV_ABS   = 2'b10,
    CONV_NEG   = 2'b11
  } conv_mode_t;

  localparam int unsigned CONV_MAX_W = 64;

  function automatic logic [CONV_MAX_W-1:0] conv_min(input int unsigned n);
    return {{(CONV_MAX_W-1){1'b0}}, 1'b1} << (n - 1);
  endfunction

endpackage

// File: rtl/u2_conv_pipe_if.sv
// u2_conv_pipe_if: valid/ready handshake bundle for the conversion pipeline.
//   in_valid/in_ready/in_mode/in_data     : operand channel into the block
//   out_valid/out_ready/out_data/out_error: result channel out of the block
//   modport slave  : the conversion block's view
//   modport master : the producer/consumer view around the block
interface u2_conv_pipe_if #(parameter int N = 8) ();
  import exe_conv_pkg::*;

  logic         in_valid;
  logic         in_ready;
  conv_mode_t   in_mode;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_error;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_error
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_error
  );

endinterface

// File: rtl/u2_conv_core.sv
// u2_conv_core: combinational U2/SM conversion of one N-bit operand.
//   mode   : conversion to apply (U2->SM, SM->U2, ABS, NEG)
//   data   : operand
//   result : converted value
//   error  : set when the result cannot be represented (MIN input to
//            U2->SM, ABS or NEG)
module u2_conv_core
  import exe_conv_pkg::*;
#(
  parameter int N = 8
) (
  input  conv_mode_t   mode,
  input  logic [N-1:0] data,
  output logic [N-1:0] result,
  output logic         error
);

  localparam logic [N-1:0] MIN = N'(conv_min(N));

  logic signed [N-1:0] data_s;
  logic signed [N-1:0] neg_s;
  logic signed [N-1:0] mag_neg_s;
  logic                is_min;

  assign data_s    = signed'(data);
  assign neg_s     = -data_s;
  // Negated magnitude of a sign-magnitude word; negative zero yields 0.
  assign mag_neg_s = -signed'({1'b0, data[N-2:0]});
  assign is_min    = (data == MIN);

  always_comb begin
    result = data;
    error  = 1'b0;
    case (mode)
      CONV_U2_SM: begin
        if (data_s < 0) begin
          if (is_min) begin
            // -MIN has no sign-magnitude encoding.
            result = '0;
            error  = 1'b1;
          end else begin
            result = {1'b1, neg_s[N-2:0]};
          end
        end
      end
      CONV_SM_U2: begin
        if (data[N-1]) result = mag_neg_s;
      end
      CONV_ABS: begin
        // |MIN| wraps back to MIN in N bits.
        if (data_s < 0) begin
          result = neg_s;
          error  = is_min;
        end
      end
      CONV_NEG: begin
        result = neg_s;
        error  = is_min;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/u2_conv_pipe.sv
// u2_conv_pipe: two-stage pipelined U2/SM converter with valid/ready flow
// control and a saturating count of errored results.
//   pclk    : clock, all state updates on the rising edge
//   presetn : synchronous active-low reset, discards items in flight
//   bus     : operand/result handshake channel (slave side)
//   err_clr : synchronous clear of err_cnt, wins over a same-cycle increment
//   err_cnt : number of errored results delivered, saturating at 2^CW-1
//   busy    : either pipeline stage holds an item
module u2_conv_pipe
  import exe_conv_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic           pclk,
  input  logic           presetn,
  u2_conv_pipe_if.slave  bus,
  input  logic           err_clr,
  output logic [CW-1:0]  err_cnt,
  output logic           busy
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic          s1_valid_q, s1_valid_d;
  conv_mode_t    s1_mode_q;
  logic [N-1:0]  s1_data_q;
  logic          s2_valid_q, s2_valid_d;
  logic [N-1:0]  s2_data_q;
  logic          s2_err_q;
  logic [CW-1:0] err_cnt_q, err_cnt_d;

  logic          adv1, adv2;
  logic          out_xfer;
  logic [N-1:0]  conv_result;
  logic          conv_error;

  // A stage may load when it is empty or its contents move on this edge,
  // so a full pipeline still streams one item per cycle.
  assign adv2     = !s2_valid_q || bus.out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign out_xfer = s2_valid_q && bus.out_ready;

  assign s1_valid_d = adv1 ? bus.in_valid : s1_valid_q;
  assign s2_valid_d = adv2 ? s1_valid_q   : s2_valid_q;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)                   err_cnt_d = '0;
    else if (out_xfer && s2_err_q) err_cnt_d = sat_inc(err_cnt_q);
  end

  // ---- S1: operand capture ----
  always_ff @(posedge pclk) begin
    if (adv1 && bus.in_valid) begin
      s1_mode_q <= bus.in_mode;
      s1_data_q <= bus.in_data;
    end
  end

  u2_conv_core #(.N(N)) u_core (
    .mode   (s1_mode_q),
    .data   (s1_data_q),
    .result (conv_result),
    .error  (conv_error)
  );

  // ---- S2: converted result, plus handshake state and error counter ----
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      err_cnt_q  <= err_cnt_d;
      // Only overwrite on a real item so an empty pipe shows the last result.
      if (adv2 && s1_valid_q) begin
        s2_data_q <= conv_result;
        s2_err_q  <= conv_error;
      end
    end
  end

  assign bus.in_ready  = adv1 && presetn;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_error = s2_err_q;
  assign err_cnt       = err_cnt_q;
  assign busy          = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_u2_conv_pipe.sv
module tb_u2_conv_pipe;
  import exe_conv_pkg::*;

  localparam int N    = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int FULL = 1 << N;
  localparam int HALF = 1 << (N - 1);

  logic          clk = 1'b0;
  logic          presetn = 1'b0;
  logic          err_clr = 1'b0;
  logic [CW-1:0] err_cnt;
  logic          busy;

  u2_conv_pipe_if #(.N(N)) bus ();

  u2_conv_pipe #(.N(N), .CW(CW)) dut (
    .pclk    (clk),
    .presetn (presetn),
    .bus     (bus),
    .err_clr (err_clr),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Conversion rules evaluated on plain integers.
  function automatic void spec_conv(input int mode, input int d, output int r, output int e);
    int v;
    v = (d >= HALF) ? d - FULL : d;
    e = 0;
    r = d;
    case (mode)
      0: begin
        if (v >= 0)          r = v;
        else if (v == -HALF) begin r = 0; e = 1; end
        else                 r = HALF + (-v);
      end
      1: r = (d >= HALF) ? (FULL - (d - HALF)) % FULL : d;
      2: begin
        r = (v < 0) ? -v : v;
        if (r == HALF) e = 1;
      end
      default: begin
        r = ((-v) % FULL + FULL) % FULL;
        e = (v == -HALF) ? 1 : 0;
      end
    endcase
  endfunction

  // Reference model: items accepted but not yet delivered, in order.
  typedef struct {
    int acc;
    int data;
    int err;
  } item_t;

  item_t q[$];
  int    e_cnt     = 0;
  int    last_out  = 0;
  int    last_data = 0;
  int    cnt       = 0;
  int    n_deliv   = 0;
  bit    started   = 0;
  bit    saw_stall = 0;

  // An item captured at edge a reaches the output after edge a+1 (it is
  // presented in cycle c and shows in cycle c+2), but never before the
  // edge on which the item ahead of it left.
  function automatic bit head_visible(input int t);
    int v;
    if (q.size() == 0) return 1'b0;
    v = (q[0].acc + 1 > last_out) ? q[0].acc + 1 : last_out;
    return v <= t;
  endfunction

  always @(posedge clk) begin
    bit    mv;
    bit    xin;
    item_t h;
    item_t n;
    int    r;
    int    e;
    e_cnt++;
    started = 1;
    if (!presetn) begin
      q.delete();
      cnt       = 0;
      last_out  = e_cnt;
      last_data = 0;
    end else begin
      mv  = head_visible(e_cnt - 1);
      xin = bus.in_valid && (q.size() < 2 || bus.out_ready);
      if (mv && bus.out_ready) begin
        h = q.pop_front();
        last_data = h.data;
        last_out  = e_cnt;
        n_deliv++;
        if (h.err != 0 && cnt < CMAX) cnt++;
      end
      if (err_clr) cnt = 0;
      if (xin) begin
        spec_conv(int'(bus.in_mode), int'(bus.in_data), r, e);
        n.acc  = e_cnt;
        n.data = r;
        n.err  = e;
        q.push_back(n);
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (started) begin
      ev = head_visible(e_cnt);
      chk("in_ready", bus.in_ready, presetn && (q.size() < 2 || bus.out_ready));
      chk("out_valid", bus.out_valid, ev);
      chk("busy", busy, q.size() > 0);
      chk("err_cnt", err_cnt, cnt);
      if (ev) begin
        chk("out_data", bus.out_data, q[0].data);
        chk("out_error", bus.out_error, q[0].err);
      end else begin
        chk("out_data_hold", bus.out_data, last_data);
      end
      if (presetn && !bus.in_ready) saw_stall = 1;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int mode, input int d);
    bit a;
    bus.in_valid = 1'b1;
    bus.in_mode  = conv_mode_t'(mode[1:0]);
    bus.in_data  = d[N-1:0];
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      a = bus.in_ready;
      @(posedge clk);
      #1;
      if (a) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    fail_now("send");
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    fail_now("drain");
  endtask

  // mode, input, expected result, expected error
  int vec [10][4] = '{
    '{0, 'h78, 'h78, 0}, '{0, 'hF8, 'h88, 0}, '{0, 'h80, 'h00, 1},
    '{1, 'h88, 'hF8, 0}, '{1, 'h80, 'h00, 0}, '{1, 'h05, 'h05, 0},
    '{2, 'hF8, 'h08, 0}, '{3, 'h05, 'hFB, 0}, '{3, 'h80, 'h80, 1},
    '{2, 'h80, 'h80, 1}
  };

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int e;
    int base;
    bit seen;
    bus.in_valid  = 1'b0;
    bus.in_mode   = CONV_U2_SM;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_out_data", bus.out_data, 0);
    sync();
    presetn = 1'b1;

    // Pin the model to hand-computed values
    foreach (vec[i]) begin
      spec_conv(vec[i][0], vec[i][1], r, e);
      chk("model_data", r, vec[i][2]);
      chk("model_err", e, vec[i][3]);
    end

    // U2->SM directed, then the error count
    sync();
    for (int i = 0; i < 3; i++) send(vec[i][0], vec[i][1]);
    drain();
    chk("u2sm_err_cnt", err_cnt, 1);

    // SM->U2, ABS, NEG directed
    sync();
    for (int i = 3; i < 10; i++) send(vec[i][0], vec[i][1]);
    drain();

    // Backpressure: 6 items, out_ready low for 3 cycles after the first
    saw_stall = 0;
    base = n_deliv;
    sync();
    fork
      for (int i = 0; i < 6; i++) send(i % 4, 'h11 * (i + 3));
      begin
        sync();
        bus.out_ready = 1'b0;
        repeat (3) sync();
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_stall_seen", saw_stall, 1);
    chk("bp_delivered", n_deliv - base, 6);

    // Counter saturation and clear priority
    sync();
    err_clr = 1'b1;
    sync();
    err_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(3, 'h80);
    drain();
    chk("sat_cnt", err_cnt, CMAX);
    sync();
    bus.out_ready = 1'b0;
    send(3, 'h80);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    if (!seen) fail_now("clr_wait");
    sync();
    err_clr = 1'b1;
    bus.out_ready = 1'b1;
    sync();
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_priority", err_cnt, 0);

    // Randomized traffic
    sync();
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.in_mode   = conv_mode_t'($urandom_range(0, 3));
      bus.in_data   = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      bus.out_ready = ($urandom_range(0, 99) < 70);
      err_clr       = ($urandom_range(0, 49) == 0);
      sync();
    end
    bus.in_valid  = 1'b0;
    err_clr       = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Errored results so the counter is non-zero before the reset
    sync();
    for (int i = 0; i < 2; i++) send(2, 'h80);
    drain();

    // Reset with 2 items in flight
    sync();
    bus.out_ready = 1'b0;
    send(0, 'h78);
    send(0, 'h05);
    presetn = 1'b0;
    sync();
    presetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    sync();
    bus.out_ready = 1'b1;
    send(0, 'hF8);
    @(negedge clk);
    chk("lat_early_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_data", bus.out_data, 'h88);
    chk("lat_error", bus.out_error, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
